// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between requesters, the shared ALU and the
// sequencer that time-shares it.
interface alu_share_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_in1;
    logic [32*NREQ-1:0] req_in2;
    logic [4*NREQ-1:0]  req_op;
    logic [31:0]        alu_in1;
    logic [31:0]        alu_in2;
    logic [3:0]         alu_op;
    logic [31:0]        alu_out;
    logic               alu_branch;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [31:0]        rsp_data;
    logic               rsp_branch;
    logic               busy;

    modport master (
        output req_valid, req_in1, req_in2, req_op,
        output rsp_ready, alu_out, alu_branch,
        input  req_ready, alu_in1, alu_in2, alu_op,
        input  rsp_valid, rsp_data, rsp_branch, busy
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_op,
        input  rsp_ready, alu_out, alu_branch,
        output req_ready, alu_in1, alu_in2, alu_op,
        output rsp_valid, rsp_data, rsp_branch, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between NREQ requesters:
// grant, drive registered operands, capture result, hand it back.
module alu_share_arbiter #(
    parameter int NREQ      = 3,
    parameter int PRIO_MODE = 0
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 2) ? 2 : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   ptrNext;
    logic [NREQ-1:0] rspValid;
    logic            busyQ;
    logic [31:0]     in1Q;
    logic [31:0]     in2Q;
    logic [3:0]      opQ;
    logic [31:0]     dataQ;
    logic            branchQ;
    logic            anyValid;
    logic            rspDone;
    logic            take;

    // Search starts at ptr (round-robin) or index 0 (fixed priority).
    always_comb begin
        int   idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (PRIO_MODE != 0) ? k : int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                winner = idx[GW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign ptrNext  = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    assign anyValid = |bus.req_valid;
    assign rspDone  = (state == RESP) && bus.rsp_ready[grant];
    assign take     = anyValid && ((state == IDLE) || rspDone);

    always_comb begin
        bus.req_ready = '0;
        if (take) bus.req_ready[winner] = 1'b1;
    end

    assign bus.alu_in1    = in1Q;
    assign bus.alu_in2    = in2Q;
    assign bus.alu_op     = opQ;
    assign bus.rsp_valid  = rspValid;
    assign bus.rsp_data   = dataQ;
    assign bus.rsp_branch = branchQ;
    assign bus.busy       = busyQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            rspValid <= '0;
            busyQ    <= 1'b0;
            in1Q     <= '0;
            in2Q     <= '0;
            opQ      <= '0;
            dataQ    <= '0;
            branchQ  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (anyValid) begin
                        state <= EXEC;
                        busyQ <= 1'b1;
                    end
                end
                EXEC: begin
                    dataQ    <= bus.alu_out;
                    branchQ  <= bus.alu_branch;
                    rspValid <= ONE << grant;
                    state    <= RESP;
                end
                RESP: begin
                    if (rspDone) begin
                        rspValid <= '0;
                        state    <= anyValid ? EXEC : IDLE;
                        busyQ    <= anyValid;
                    end
                end
                default: state <= IDLE;
            endcase
            // Back-to-back grants from RESP share this path with IDLE.
            if (take) begin
                in1Q  <= bus.req_in1[32*int'(winner) +: 32];
                in2Q  <= bus.req_in2[32*int'(winner) +: 32];
                opQ   <= bus.req_op[4*int'(winner) +: 4];
                grant <= winner;
                if (PRIO_MODE == 0) ptr <= ptrNext;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for the shared-ALU sequencer: randomized and
// directed requests against a cycle-level reference model.
module tb_alu_share_arbiter;
    localparam int N = 3;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_BNE = 4'd9;

    typedef struct {
        int          w;
        logic [31:0] data;
        logic        br;
        int          acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter_if #(.NREQ(N)) b ();
    alu_share_arbiter_if #(.NREQ(N)) bp ();

    alu_share_arbiter #(.NREQ(N), .PRIO_MODE(0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b.slave)
    );

    alu_share_arbiter #(.NREQ(N), .PRIO_MODE(1)) dutP (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bp.slave)
    );

    function automatic logic [32:0] aluF(input logic [31:0] a,
                                         input logic [31:0] c,
                                         input logic [3:0]  op);
        logic [31:0] r;
        logic        br;
        r  = a;
        br = 1'b0;
        case (op)
            OP_ADD: r = a + c;
            OP_SUB: r = a - c;
            OP_AND: r = a & c;
            OP_OR:  r = a | c;
            OP_XOR: r = a ^ c;
            OP_SLT: r = {31'b0, $signed(a) < $signed(c)};
            OP_BEQ: begin r = a - c; br = (a == c); end
            OP_BNE: begin r = a - c; br = (a != c); end
            default: r = a;
        endcase
        return {br, r};
    endfunction

    wire logic [32:0] aluB = aluF(b.alu_in1, b.alu_in2, b.alu_op);
    wire logic [32:0] aluP = aluF(bp.alu_in1, bp.alu_in2, bp.alu_op);
    assign b.alu_out     = aluB[31:0];
    assign b.alu_branch  = aluB[32];
    assign bp.alu_out    = aluP[31:0];
    assign bp.alu_branch = aluP[32];

    logic [N-1:0] vld;
    logic [N-1:0] rspRdy;
    logic [31:0]  in1s[N];
    logic [31:0]  in2s[N];
    logic [3:0]   ops[N];
    exp_t         sbq[$];

    bit outst;
    int ow;
    int age;
    int p;
    int lastAcc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        b.req_valid = vld;
        b.rsp_ready = rspRdy;
        for (int i = 0; i < N; i++) begin
            b.req_in1[32*i +: 32] = in1s[i];
            b.req_in2[32*i +: 32] = in2s[i];
            b.req_op[4*i +: 4]    = ops[i];
        end
    endtask

    task automatic newOp(input int i);
        logic [3:0] tbl[8];
        tbl = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_SLT, OP_BEQ, OP_BNE};
        ops[i]  = tbl[$urandom_range(0, 7)];
        in1s[i] = $urandom;
        in2s[i] = ($urandom_range(0, 3) == 0) ? in1s[i] : $urandom;
        vld[i]  = 1'b1;
    endtask

    // One cycle: drive at negedge, sample just before posedge, check
    // req_ready against the model and record accepted operations.
    task automatic step();
        logic [N-1:0] expRdy;
        logic [32:0]  r;
        bit           allowed;
        bit           rspHs;
        int           expW;
        int           j;
        @(negedge clk);
        drive();
        #4;
        if (outst) age++;
        rspHs   = outst && age >= 2 && b.rsp_ready[ow];
        allowed = !outst || rspHs;
        expW    = -1;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (expW < 0 && vld[j]) expW = j;
        end
        expRdy = '0;
        if (allowed && expW >= 0) expRdy[expW] = 1'b1;
        chk("req_ready", b.req_ready, expRdy);
        lastAcc = -1;
        for (int i = 0; i < N; i++)
            if (lastAcc < 0 && vld[i] && b.req_ready[i]) lastAcc = i;
        if (lastAcc >= 0) begin
            r = aluF(in1s[lastAcc], in2s[lastAcc], ops[lastAcc]);
            sbq.push_back('{w: lastAcc, data: r[31:0], br: r[32],
                            acc: cyc});
            vld[lastAcc] = 1'b0;
        end
        if (rspHs) outst = 1'b0;
        if (allowed && expW >= 0) begin
            outst = 1'b1;
            ow    = expW;
            age   = 0;
            p     = (expW + 1) % N;
        end
    endtask

    task automatic untilAcc(input int i);
        int t;
        t       = 0;
        lastAcc = -1;
        while (lastAcc != i && t < 20) begin
            step();
            t++;
        end
        chk("accept_wait", lastAcc, i);
    endtask

    task automatic drain();
        int t;
        t      = 0;
        vld    = '0;
        rspRdy = '1;
        while (sbq.size() > 0 && t < 20) begin
            step();
            t++;
        end
        step();
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n        = 1'b0;
        vld          = '0;
        rspRdy       = '0;
        drive();
        bp.req_valid = '0;
        sbq.delete();
        outst        = 1'b0;
        p            = 0;
        @(negedge clk);
        #4;
        chk("rst_req_ready", b.req_ready, 0);
        chk("rst_rsp_valid", b.rsp_valid, 0);
        chk("rst_rsp_data", b.rsp_data, 0);
        chk("rst_rsp_branch", b.rsp_branch, 0);
        chk("rst_alu_in1", b.alu_in1, 0);
        chk("rst_alu_in2", b.alu_in2, 0);
        chk("rst_alu_op", b.alu_op, 0);
        chk("rst_busy", b.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rrRun(input int n);
        int cnt;
        int prev;
        int t;
        cnt    = 0;
        prev   = 0;
        t      = 0;
        rspRdy = '1;
        while (cnt < n && t < 4 * n) begin
            for (int i = 0; i < N; i++) if (!vld[i]) newOp(i);
            step();
            t++;
            if (lastAcc >= 0) begin
                chk("rr_order", lastAcc, cnt % N);
                if (cnt > 0) chk("rr_gap", cyc - prev, 2);
                prev = cyc;
                cnt++;
            end
        end
        chk("rr_count", cnt, n);
    endtask

    task automatic prioTest();
        int g0;
        int t;
        bit got;
        @(negedge clk);
        bp.rsp_ready        = '1;
        bp.req_in1[31:0]    = 32'd1;
        bp.req_in2[31:0]    = 32'd2;
        bp.req_op[3:0]      = OP_ADD;
        bp.req_in1[95:64]   = 32'd100;
        bp.req_in2[95:64]   = 32'd1;
        bp.req_op[11:8]     = OP_ADD;
        bp.req_valid        = 3'b101;
        g0 = 0;
        for (int k = 0; k < 8; k++) begin
            #4;
            chk("prio_no_r2", bp.req_ready[2], 0);
            if (bp.req_ready[0]) g0++;
            @(negedge clk);
        end
        chk("prio_r0_grants", g0, 4);
        bp.req_valid = 3'b100;
        t   = 0;
        got = 1'b0;
        while (!got && t < 4) begin
            #4;
            got = (bp.req_ready == 3'b100);
            t++;
            @(negedge clk);
        end
        chk("prio_r2_grant", got, 1);
        chk("prio_r2_wait", t, 1);
        bp.req_valid = '0;
        t   = 0;
        got = 1'b0;
        while (!got && t < 4) begin
            #4;
            got = (bp.rsp_valid == 3'b100);
            t++;
            if (!got) @(negedge clk);
        end
        chk("prio_r2_rsp", got, 1);
        chk("prio_r2_data", bp.rsp_data, 101);
    endtask

    // Monitor: compare every presented response against the queue head.
    initial begin
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (sbq.size() > 0 && cyc >= sbq[0].acc + 2) begin
                    e     = sbq[0];
                    oh    = '0;
                    oh[e.w] = 1'b1;
                    chk("rsp_valid", b.rsp_valid, oh);
                    chk("rsp_data", b.rsp_data, e.data);
                    chk("rsp_branch", b.rsp_branch, e.br);
                    if (b.rsp_ready[e.w]) void'(sbq.pop_front());
                end else begin
                    chk("rsp_quiet", b.rsp_valid, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vld    = '0;
        rspRdy = '0;
        for (int i = 0; i < N; i++) begin
            in1s[i] = '0;
            in2s[i] = '0;
            ops[i]  = '0;
        end
        drive();
        bp.req_valid = '0;
        bp.rsp_ready = '0;
        bp.req_in1   = '0;
        bp.req_in2   = '0;
        bp.req_op    = '0;
        outst = 1'b0;
        ow    = 0;
        age   = 0;
        p     = 0;

        doReset();

        rspRdy  = 3'b001;
        in1s[0] = 32'd5;
        in2s[0] = 32'd7;
        ops[0]  = OP_ADD;
        vld[0]  = 1'b1;
        untilAcc(0);
        step();
        chk("single_alu_in1", b.alu_in1, 5);
        chk("single_alu_in2", b.alu_in2, 7);
        chk("single_alu_op", b.alu_op, OP_ADD);
        chk("single_busy", b.busy, 1);
        step();
        chk("single_rsp_valid", b.rsp_valid, 3'b001);
        chk("single_rsp_data", b.rsp_data, 12);
        step();
        chk("single_idle", b.busy, 0);

        doReset();
        rrRun(5);

        drain();
        rspRdy  = '0;
        in1s[1] = 32'd9;
        in2s[1] = 32'd4;
        ops[1]  = OP_SUB;
        vld[1]  = 1'b1;
        untilAcc(1);
        newOp(0);
        step();
        for (int h = 0; h < 5; h++) begin
            rspRdy = (h == 2) ? 3'b001 : 3'b000;
            step();
            chk("bp_valid", b.rsp_valid, 3'b010);
            chk("bp_data", b.rsp_data, 5);
        end
        rspRdy = 3'b010;
        step();

        drain();
        in1s[2] = 32'h1234;
        in2s[2] = 32'h1234;
        ops[2]  = OP_BEQ;
        vld[2]  = 1'b1;
        untilAcc(2);
        step();
        step();
        chk("beq_equal", b.rsp_branch, 1);
        in2s[2] = 32'h1235;
        vld[2]  = 1'b1;
        untilAcc(2);
        step();
        step();
        chk("beq_differ", b.rsp_branch, 0);

        drain();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 99) < 40) newOp(i);
                else if (vld[i] && $urandom_range(0, 99) < 3)
                    vld[i] = 1'b0;
                rspRdy[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        drain();
        newOp(0);
        untilAcc(0);
        doReset();
        rrRun(3);

        drain();
        prioTest();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that time-shares the single combinational `alu` between up to NREQ requesters (fetch PC increment, branch/jump target, load/store address generation, execute) in the multi-cycle core. It arbitrates valid/ready requests, registers the winner's operands and opcode onto the ALU inputs, captures `aluOut`/`branch` one cycle later, and returns the result to the granted requester under a valid/ready handshake.

## Interface
- NREQ, 3, number of requesters (2..4); requester i uses slice i of every packed bus.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (index 0 highest).
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- req_valid  in  NREQ  requester i presents an operation.
- req_ready  out  NREQ  one-hot accept pulse; a request is taken when req_valid[i] & req_ready[i].
- req_in1  in  32*NREQ  operand 1 per requester.
- req_in2  in  32*NREQ  operand 2 per requester.
- req_op  in  4*NREQ  ALU opcode per requester (`defines.v` codes, passed through unmodified).
- alu_in1, alu_in2  out  32  registered operands to the ALU.
- alu_op  out  4  registered opcode to the ALU.
- alu_out  in  32  ALU result (combinational from alu_in*/alu_op).
- alu_branch  in  1  ALU branch predicate.
- rsp_valid  out  NREQ  one-hot; result available for requester i.
- rsp_ready  in  NREQ  requester i consumes result.
- rsp_data  out  32  captured ALU result.
- rsp_branch  out  1  captured branch predicate.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, select winner w, assert req_ready[w] combinationally for that cycle, latch req_in1/in2/op[w] into alu_in1/alu_in2/alu_op and w into grant register; go EXEC. No request: stay IDLE, req_ready = 0.
- EXEC (exactly one cycle): capture alu_out -> rsp_data, alu_branch -> rsp_branch; go RESP.
- RESP: rsp_valid[w] = 1; rsp_data/rsp_branch/alu_* held stable. Stay until rsp_ready[w]. On rsp_ready[w]: if any req_valid that same cycle, perform the IDLE grant action directly (back-to-back) and go EXEC; else go IDLE. rsp_ready of non-granted requesters ignored.
- req_ready is zero in EXEC and in RESP without rsp_ready[w].
- Round-robin: pointer p (index of highest priority); search p, p+1, … mod NREQ; after a grant to w, p = (w+1) mod NREQ. Pointer changes only on a grant.
- Fixed priority: lowest index with req_valid wins; pointer unused.
- Requester may drop req_valid before it is accepted; no state effect.
- Opcodes not interpreted; the block never alters operands or result width (32-bit, no extension).

## Timing
- Reset (rst_n low at a rising edge): state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_branch 0, alu_in1/alu_in2 0, alu_op 4'b0000, grant 0, p 0, busy 0. An in-flight operation is discarded with no response.
- Accept at cycle N -> alu_* valid from N+1 -> rsp_valid high from N+2.
- Minimum issue interval 2 cycles (accept N, rsp_ready at N+2 with back-to-back accept at N+2).
- rsp_valid stays high indefinitely with rsp_ready low; all outputs stable meanwhile.

## Test plan
- Single op: reset, req0 in1=5 in2=7 op `ADD -> req_ready[0] at N, alu_in1=5 at N+1, rsp_valid=3'b001, rsp_data=12 at N+2; rsp_ready[0] -> IDLE, busy 0.
- Round-robin: all three requesters valid continuously, rsp_ready held 1 -> grant order 0,1,2,0,1 with accepts every 2 cycles, rsp_valid one-hot matching.
- Backpressure: req1 `SUB 9-4, rsp_ready[1] low 5 cycles -> rsp_valid[1] and rsp_data=5 held stable 5 cycles; rsp_ready[0] pulse ignored; req_ready stays 0.
- Branch: req2 op `BEQ in1=in2=0x1234 -> rsp_branch=1; in2=0x1235 -> rsp_branch=0.
- Reset mid-op: assert rst_n low in EXEC -> next cycle all outputs at reset values, no rsp_valid ever issued for that op, p = 0.
- PRIO_MODE=1: req0 and req2 valid continuously -> req2 never granted while req0 valid; drop req0 -> req2 granted next IDLE/RESP-handshake cycle.
